// File: rtl/z80_io_write_qualifier.sv
// z80_io_write_qualifier: synchronises the Z80 I/O strobes and turns each complete OUT to port 7xh into one bank write pulse
module z80_io_write_qualifier #(
  parameter int          SYNC_STAGES    = 2,
  parameter logic [3:0]  PORT_ADDR      = 4'b0111,
  parameter int          MIN_LOW_CYCLES = 2,
  parameter int          TIMEOUT        = 255
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic [3:0] AddrIO,
  input  logic       IORQ_N,
  input  logic       WR_N,
  input  logic       RD_N,
  input  logic       M1_N,
  input  logic [1:0] D1D0,
  output logic       bank_wr_stb,
  output logic [1:0] bank_data,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] wr_count
);
  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  MIN_C    = CW'(MIN_LOW_CYCLES);
  localparam logic [CW-1:0]  TO_C     = CW'(TIMEOUT);
  localparam logic [9:0]     BUS_IDLE = 10'b1111_0000_00;
  typedef enum logic [2:0] {S_IDLE, S_FILTER, S_ACTIVE, S_DONE, S_ABORT} state_t;
  logic [SYNC_STAGES-1:0][9:0] r_sync;
  logic [9:0]    w_bus;
  logic          w_q;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [1:0]    r_cap, w_cap_next;
  logic          w_set_err;
  logic          r_stb, r_busy, r_err;
  logic [1:0]    r_data;
  logic [7:0]    r_count;
  assign w_bus = r_sync[SYNC_STAGES-1];
  assign w_q   = ~w_bus[9] & ~w_bus[8] & w_bus[7] & w_bus[6] & (w_bus[5:2] == PORT_ADDR);
  // Bus synchroniser: every input shifts through SYNC_STAGES flops, reset to an idle bus
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) r_sync <= {SYNC_STAGES{BUS_IDLE}};
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], {IORQ_N, WR_N, RD_N, M1_N, AddrIO, D1D0}};
  // Next-state logic: glitch filter, data capture while the write is held, abort on a stuck strobe
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_cap_next = r_cap;
    w_set_err  = 1'b0;
    case (r_state)
      S_IDLE:   if (w_q) begin w_next = S_FILTER; w_cnt_next = CW'(1); end
      S_FILTER: if (!w_q) w_next = S_IDLE;
                else if (r_cnt == MIN_C) begin w_next = S_ACTIVE; w_cnt_next = '0; end
                else w_cnt_next = r_cnt + 1'b1;
      S_ACTIVE: if (!w_q) w_next = S_DONE;
                else if (r_cnt == TO_C) begin w_next = S_ABORT; w_set_err = 1'b1; end
                else begin w_cap_next = w_bus[1:0]; w_cnt_next = r_cnt + 1'b1; end
      S_DONE:   w_next = S_IDLE;
      S_ABORT:  w_next = w_q ? S_ABORT : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  // State register plus registered outputs decoded from the current state
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cap   <= 2'b01;
      r_stb   <= 1'b0;
      r_data  <= 2'b01;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_cap   <= w_cap_next;
      r_stb   <= r_state == S_DONE;
      r_busy  <= (r_state == S_FILTER) || (r_state == S_ACTIVE) || (r_state == S_ABORT);
      if (w_set_err) r_err <= 1'b1;
      if (r_state == S_DONE) begin
        r_data  <= r_cap;
        r_count <= r_count + 8'd1;
      end
    end
  assign bank_wr_stb = r_stb;
  assign bank_data   = r_data;
  assign busy        = r_busy;
  assign timeout_err = r_err;
  assign wr_count    = r_count;
endmodule

// File: tb/tb_z80_io_write_qualifier.sv
// tb_z80_io_write_qualifier: table-driven, directed and randomized checks of the bank write qualifier
module tb_z80_io_write_qualifier;
  localparam int SS  = 2;
  localparam int MIN = 2;
  localparam int TO  = 255;
  logic       clk, RESET_N, IORQ_N, WR_N, RD_N, M1_N;
  logic [3:0] AddrIO;
  logic [1:0] D1D0;
  logic       bank_wr_stb, busy, timeout_err;
  logic [1:0] bank_data;
  logic [7:0] wr_count;
  int n_tests = 0, n_fail = 0, n_stb = 0, exp_cnt = 0, base, lat;
  logic [1:0] model_cap;
  typedef struct {
    logic [3:0] a;
    logic       m1, rd, wr;
    logic [1:0] d;
    int         len;
    int         exp_stb;
    logic [1:0] exp_data;
  } vec_t;
  vec_t tbl [10];
  z80_io_write_qualifier #(.SYNC_STAGES(SS), .PORT_ADDR(4'b0111), .MIN_LOW_CYCLES(MIN), .TIMEOUT(TO)) dut (
    .clk(clk), .RESET_N(RESET_N), .AddrIO(AddrIO), .IORQ_N(IORQ_N), .WR_N(WR_N), .RD_N(RD_N),
    .M1_N(M1_N), .D1D0(D1D0), .bank_wr_stb(bank_wr_stb), .bank_data(bank_data), .busy(busy),
    .timeout_err(timeout_err), .wr_count(wr_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (bank_wr_stb) n_stb++;
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic bus_cycle(input logic [3:0] a, input logic m1, input logic rd, input logic wr,
                           input logic [1:0] d, input int len);
    @(negedge clk);
    AddrIO = a; D1D0 = d; M1_N = m1; RD_N = rd; IORQ_N = 1'b0; WR_N = wr;
    repeat (len) @(negedge clk);
    IORQ_N = 1'b1; WR_N = 1'b1; RD_N = 1'b1; M1_N = 1'b1;
  endtask
  task automatic settle();
    repeat (6) @(negedge clk);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    RESET_N = 1'b0;
    @(negedge clk);
    RESET_N = 1'b1;
  endtask
  initial begin
    tbl[0] = '{4'h7, 1'b1, 1'b1, 1'b0, 2'b01, 4, 1, 2'b01};
    tbl[1] = '{4'h7, 1'b1, 1'b1, 1'b0, 2'b11, 8, 1, 2'b11};
    tbl[2] = '{4'h7, 1'b1, 1'b1, 1'b0, 2'b00, 2, 0, 2'b11};
    tbl[3] = '{4'h6, 1'b1, 1'b1, 1'b0, 2'b10, 6, 0, 2'b11};
    tbl[4] = '{4'h7, 1'b0, 1'b1, 1'b0, 2'b10, 6, 0, 2'b11};
    tbl[5] = '{4'h7, 1'b1, 1'b0, 1'b0, 2'b10, 6, 0, 2'b11};
    tbl[6] = '{4'h7, 1'b1, 1'b1, 1'b1, 2'b10, 6, 0, 2'b11};
    tbl[7] = '{4'hF, 1'b1, 1'b1, 1'b0, 2'b01, 6, 0, 2'b11};
    tbl[8] = '{4'h7, 1'b1, 1'b1, 1'b0, 2'b10, 5, 1, 2'b10};
    tbl[9] = '{4'h7, 1'b1, 1'b1, 1'b0, 2'b00, 4, 1, 2'b00};
    RESET_N = 1'b0; IORQ_N = 1'b1; WR_N = 1'b1; RD_N = 1'b1; M1_N = 1'b1; AddrIO = 4'h0; D1D0 = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_stb", bank_wr_stb, 0);
    check("reset_data", bank_data, 1);
    check("reset_busy", busy, 0);
    check("reset_err", timeout_err, 0);
    check("reset_cnt", wr_count, 0);
    RESET_N = 1'b1;
    repeat (2) @(negedge clk);
    // OUT (7Ah),2 with release latency measurement
    base = n_stb;
    AddrIO = 4'h7; D1D0 = 2'b10; IORQ_N = 1'b0; WR_N = 1'b0;
    repeat (6) @(negedge clk);
    check("t1_busy", busy, 1);
    IORQ_N = 1'b1; WR_N = 1'b1;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (bank_wr_stb) begin lat = n; break; end
    end
    check("t1_latency", lat, SS + 2);
    settle();
    exp_cnt = 1;
    check("t1_nstb", n_stb - base, 1);
    check("t1_data", bank_data, 2);
    check("t1_cnt", wr_count, exp_cnt);
    check("t1_busy_idle", busy, 0);
    // one-clock glitch
    base = n_stb;
    bus_cycle(4'h7, 1'b1, 1'b1, 1'b0, 2'b01, 1);
    settle();
    check("t2_nstb", n_stb - base, 0);
    check("t2_cnt", wr_count, exp_cnt);
    check("t2_busy", busy, 0);
    // interrupt acknowledge, then wrong port
    base = n_stb;
    bus_cycle(4'h7, 1'b0, 1'b1, 1'b0, 2'b11, 6);
    settle();
    check("t3_intack_nstb", n_stb - base, 0);
    bus_cycle(4'h6, 1'b1, 1'b1, 1'b0, 2'b11, 6);
    settle();
    check("t3_port6_nstb", n_stb - base, 0);
    check("t3_data", bank_data, 2);
    // table-driven vectors
    foreach (tbl[i]) begin
      base = n_stb;
      bus_cycle(tbl[i].a, tbl[i].m1, tbl[i].rd, tbl[i].wr, tbl[i].d, tbl[i].len);
      settle();
      if (tbl[i].exp_stb != 0) begin exp_cnt++; model_cap = tbl[i].exp_data; end
      check($sformatf("tbl%0d_nstb", i), n_stb - base, tbl[i].exp_stb);
      check($sformatf("tbl%0d_data", i), bank_data, tbl[i].exp_data);
      check($sformatf("tbl%0d_cnt", i), wr_count, exp_cnt % 256);
    end
    // randomized transactions against a run-length reference model
    for (int k = 0; k < 200; k++) begin
      logic [3:0] a;
      logic m1, rd, wr, qual;
      logic [1:0] d;
      int len, es;
      a   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h7;
      m1  = $urandom_range(0, 7) != 0;
      rd  = $urandom_range(0, 7) != 0;
      wr  = $urandom_range(0, 7) == 0;
      d   = 2'($urandom);
      len = $urandom_range(1, 10);
      qual = (a == 4'h7) && m1 && rd && !wr;
      if (qual && len >= MIN + 2) model_cap = d;
      es = (qual && len >= MIN + 1) ? 1 : 0;
      exp_cnt += es;
      base = n_stb;
      bus_cycle(a, m1, rd, wr, d, len);
      settle();
      check($sformatf("rnd%0d_nstb", k), n_stb - base, es);
      check($sformatf("rnd%0d_data", k), bank_data, model_cap);
      check($sformatf("rnd%0d_cnt", k), wr_count, exp_cnt % 256);
    end
    // stuck write strobe forces an abort, then a normal OUT (70h),3
    base = n_stb;
    check("t4_err_before", timeout_err, 0);
    bus_cycle(4'h7, 1'b1, 1'b1, 1'b0, 2'b01, 300);
    check("t4_busy_abort", busy, 1);
    settle();
    check("t4_err", timeout_err, 1);
    check("t4_nstb", n_stb - base, 0);
    check("t4_busy_idle", busy, 0);
    bus_cycle(4'h7, 1'b1, 1'b1, 1'b0, 2'b11, 6);
    settle();
    exp_cnt++;
    check("t4_after_nstb", n_stb - base, 1);
    check("t4_after_data", bank_data, 3);
    check("t4_after_cnt", wr_count, exp_cnt % 256);
    check("t4_err_sticky", timeout_err, 1);
    // reset pulse in the middle of an active write
    base = n_stb;
    @(negedge clk);
    AddrIO = 4'h7; D1D0 = 2'b10; IORQ_N = 1'b0; WR_N = 1'b0;
    repeat (5) @(negedge clk);
    RESET_N = 1'b0;
    #1;
    check("t5_data", bank_data, 1);
    check("t5_cnt", wr_count, 0);
    check("t5_err", timeout_err, 0);
    @(negedge clk);
    RESET_N = 1'b1;
    @(negedge clk);
    IORQ_N = 1'b1; WR_N = 1'b1;
    settle();
    check("t5_nstb", n_stb - base, 0);
    check("t5_cnt_after", wr_count, 0);
    // 256 back-to-back writes with alternating data
    pulse_reset();
    base = n_stb;
    for (int i = 0; i < 256; i++) begin
      bus_cycle(4'h7, 1'b1, 1'b1, 1'b0, (i % 2 == 1) ? 2'b11 : 2'b01, 4);
      repeat (2) @(negedge clk);
    end
    settle();
    check("t6_nstb", n_stb - base, 256);
    check("t6_cnt_wrap", wr_count, 0);
    check("t6_data", bank_data, 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
